mul_issue_sched: RTL and testbench

MUL_ISSUE_SCHED -- requirements
Module: mul_issue_sched

---
 rtl/proc_pkg.sv | 12 +
 rtl/mul_issue_sched.sv | 120 ++++++++++++
 tb/tb_mul_issue_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor constants: opcode and register-index widths, the opcodes the
// issue logic decodes, and the multiplier pipeline depth.
package proc;

   localparam int unsigned OPCODE_BITS    = 6;
   localparam int unsigned REG_IDX_BITS   = 5;
   localparam int unsigned MUL_NUM_STAGES = 4;

   localparam logic [OPCODE_BITS-1:0] OPCODE_NOP = 6'h00;
   localparam logic [OPCODE_BITS-1:0] OPCODE_MUL = 6'h0c;

endpackage

// File: rtl/mul_issue_sched.sv
// Issue gate in front of the pipelined multiplier: holds the candidate on ROB-full, RAW on
// an in-flight MUL result, or a writeback-port collision, and counts held cycles.
module mul_issue_sched
   import proc::*;
#(
   parameter int unsigned NUM_STAGES = MUL_NUM_STAGES,
   parameter int unsigned ALU_LAT    = 1,
   parameter int unsigned CNT_BITS   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    instValid,
   input  logic [OPCODE_BITS-1:0]  opcodeIn,
   input  logic [REG_IDX_BITS-1:0] src1Reg,
   input  logic [REG_IDX_BITS-1:0] src2Reg,
   input  logic                    src1Used,
   input  logic                    src2Used,
   input  logic [REG_IDX_BITS-1:0] dstRegIn,
   input  logic                    robFull,
   output logic                    stall,
   output logic                    aluFire,
   output logic                    mulFire,
   output logic [OPCODE_BITS-1:0]  multOpcodeOut,
   output logic                    mulBusy,
   output logic [CNT_BITS-1:0]     stallCount
);

   typedef enum logic [1:0] {ClsNone, ClsAlu, ClsMul} inst_class_e;

   if (ALU_LAT < 1 || ALU_LAT >= NUM_STAGES) begin : gen_bad_alu_lat
      $error("ALU_LAT must lie in 1..NUM_STAGES-1");
   end

   inst_class_e cls;
   logic        raw_hazard;
   logic        struct_hazard;
   logic        fire_ok;

   // Entry k describes the MUL issued k cycles ago.
   logic [NUM_STAGES:1]                   sb_valid_q, sb_valid_d;
   logic [NUM_STAGES:1][REG_IDX_BITS-1:0] sb_dst_q, sb_dst_d;

   // resv_q[k]: writeback port already claimed k cycles from now. A MUL issued this cycle
   // claims the slot NUM_STAGES ahead, which is NUM_STAGES-1 ahead once the edge passes.
   logic [NUM_STAGES-1:1] resv_q, resv_d;

   logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      cls = ClsNone;
      if (instValid && opcodeIn != OPCODE_NOP) begin
         cls = (opcodeIn == OPCODE_MUL) ? ClsMul : ClsAlu;
      end
   end

   // No forwarding out of the multiplier: any valid entry with a matching dst blocks.
   always_comb begin
      raw_hazard = 1'b0;
      for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
         if (sb_valid_q[k] && ((src1Used && src1Reg == sb_dst_q[k]) ||
                               (src2Used && src2Reg == sb_dst_q[k]))) begin
            raw_hazard = 1'b1;
         end
      end
   end

   assign struct_hazard = (cls == ClsAlu) && resv_q[ALU_LAT];

   always_comb begin
      stall         = (cls != ClsNone) && (robFull || raw_hazard || struct_hazard);
      fire_ok       = !stall && !clear && !rst;
      mulFire       = (cls == ClsMul) && fire_ok;
      aluFire       = (cls == ClsAlu) && fire_ok;
      multOpcodeOut = mulFire ? OPCODE_MUL : OPCODE_NOP;
      mulBusy       = |sb_valid_q;
   end

   always_comb begin
      sb_valid_d  = '0;
      sb_dst_d    = sb_dst_q;
      resv_d      = '0;
      sb_dst_d[1] = dstRegIn;
      for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
         sb_dst_d[k] = sb_dst_q[k-1];
      end
      if (!clear) begin
         sb_valid_d[1]            = mulFire;
         resv_d[NUM_STAGES-1]     = mulFire;
         for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
            sb_valid_d[k] = sb_valid_q[k-1];
         end
         for (int unsigned k = 1; k < NUM_STAGES - 1; k++) begin
            resv_d[k] = resv_q[k+1];
         end
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb_valid_q  <= '0;
         sb_dst_q    <= '0;
         resv_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         sb_valid_q  <= sb_valid_d;
         sb_dst_q    <= sb_dst_d;
         resv_q      <= resv_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_mul_issue_sched.sv
// Bench for mul_issue_sched: vector tables for the documented scenarios, hand sequences for
// saturation and reset, then random traffic scored against a writeback-time model.
`timescale 1ns/1ps
module tb_mul_issue_sched;
   import proc::*;

   localparam int N   = MUL_NUM_STAGES;
   localparam int LAT = 1;
   localparam logic [OPCODE_BITS-1:0] OP_ADD = 6'h01;

   typedef struct {
      logic                    valid;
      logic [OPCODE_BITS-1:0]  op;
      logic [REG_IDX_BITS-1:0] s1;
      logic [REG_IDX_BITS-1:0] s2;
      logic [REG_IDX_BITS-1:0] dst;
      logic                    s1u;
      logic                    s2u;
      logic                    rob;
      logic                    clr;
      logic                    rst;
   } in_t;

   typedef struct {
      in_t  in;
      logic stall;
      logic alu;
      logic mul;
      logic busy;
      int   cnt;
   } vec_t;

   typedef struct {
      logic [REG_IDX_BITS-1:0] dst;
      int                      issued;
   } mul_rec_t;

   logic                    clk = 1'b0;
   logic                    rst, clear, inst_valid, src1_used, src2_used, rob_full;
   logic [OPCODE_BITS-1:0]  opcode;
   logic [REG_IDX_BITS-1:0] src1, src2, dst;
   logic                    stall_a, alu_a, mul_a, busy_a;
   logic                    stall_b, alu_b, mul_b, busy_b;
   logic [OPCODE_BITS-1:0]  mop_a, mop_b;
   logic [15:0]             cnt_a;
   logic [3:0]              cnt_b;

   logic                    s_stall, s_alu, s_mul, s_busy;
   logic [OPCODE_BITS-1:0]  s_mop;
   logic [15:0]             s_cnt16;
   logic [3:0]              s_cnt4;

   mul_rec_t inflight[$];
   vec_t     tbl[$];
   int       cyc      = 0;
   int       m_cnt16  = 0;
   int       m_cnt4   = 0;
   int       n_checks = 0;
   int       n_err    = 0;

   always #5 clk = ~clk;

   mul_issue_sched #(.ALU_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .clear(clear), .instValid(inst_valid), .opcodeIn(opcode),
      .src1Reg(src1), .src2Reg(src2), .src1Used(src1_used), .src2Used(src2_used),
      .dstRegIn(dst), .robFull(rob_full), .stall(stall_a), .aluFire(alu_a),
      .mulFire(mul_a), .multOpcodeOut(mop_a), .mulBusy(busy_a), .stallCount(cnt_a)
   );

   mul_issue_sched #(.ALU_LAT(LAT), .CNT_BITS(4)) u_dut4 (
      .clk(clk), .rst(rst), .clear(clear), .instValid(inst_valid), .opcodeIn(opcode),
      .src1Reg(src1), .src2Reg(src2), .src1Used(src1_used), .src2Used(src2_used),
      .dstRegIn(dst), .robFull(rob_full), .stall(stall_b), .aluFire(alu_b),
      .mulFire(mul_b), .multOpcodeOut(mop_b), .mulBusy(busy_b), .stallCount(cnt_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic in_t idle();
      in_t v;
      v.valid = 1'b0; v.op = OPCODE_NOP; v.s1 = '0; v.s2 = '0; v.dst = '0;
      v.s1u = 1'b0; v.s2u = 1'b0; v.rob = 1'b0; v.clr = 1'b0; v.rst = 1'b0;
      return v;
   endfunction

   function automatic in_t mul_i(input int d);
      in_t v;
      v = idle();
      v.valid = 1'b1; v.op = OPCODE_MUL; v.dst = d[REG_IDX_BITS-1:0];
      return v;
   endfunction

   function automatic in_t alu_i(input int a, input logic au, input int b, input logic bu);
      in_t v;
      v = idle();
      v.valid = 1'b1; v.op = OP_ADD; v.dst = 5'd7;
      v.s1 = a[REG_IDX_BITS-1:0]; v.s1u = au;
      v.s2 = b[REG_IDX_BITS-1:0]; v.s2u = bu;
      return v;
   endfunction

   function automatic vec_t row(input in_t v, input logic st, input logic al, input logic mu,
                                input logic bu, input int cnt);
      vec_t r;
      r.in = v; r.stall = st; r.alu = al; r.mul = mu; r.busy = bu; r.cnt = cnt;
      return r;
   endfunction

   task automatic drive(input in_t v);
      inst_valid = v.valid; opcode = v.op; src1 = v.s1; src2 = v.s2; dst = v.dst;
      src1_used = v.s1u; src2_used = v.s2u; rob_full = v.rob; clear = v.clr; rst = v.rst;
   endtask

   // One cycle: drive, predict from the in-flight list, sample mid-cycle, then advance.
   task automatic step(input in_t v);
      logic     is_mul, is_alu, raw, strc, e_stall, e_alu, e_mul, e_busy;
      logic [OPCODE_BITS-1:0] e_mop;
      mul_rec_t rec;
      drive(v);
      is_mul = v.valid && v.op == OPCODE_MUL;
      is_alu = v.valid && v.op != OPCODE_MUL && v.op != OPCODE_NOP;
      raw = 1'b0; strc = 1'b0; e_busy = 1'b0;
      foreach (inflight[i]) begin
         e_busy = 1'b1;
         if ((v.s1u && v.s1 == inflight[i].dst) || (v.s2u && v.s2 == inflight[i].dst))
            raw = 1'b1;
         if (inflight[i].issued + N == cyc + LAT) strc = 1'b1;
      end
      e_stall = (is_mul || is_alu) && (v.rob || raw || (is_alu && strc));
      e_mul   = is_mul && !e_stall && !v.clr && !v.rst;
      e_alu   = is_alu && !e_stall && !v.clr && !v.rst;
      e_mop   = e_mul ? OPCODE_MUL : OPCODE_NOP;

      @(negedge clk);
      s_stall = stall_a; s_alu = alu_a; s_mul = mul_a; s_busy = busy_a;
      s_mop = mop_a; s_cnt16 = cnt_a; s_cnt4 = cnt_b;
      chk("a.stall", 32'(stall_a), 32'(e_stall));
      chk("a.aluFire", 32'(alu_a), 32'(e_alu));
      chk("a.mulFire", 32'(mul_a), 32'(e_mul));
      chk("a.multOpcodeOut", 32'(mop_a), 32'(e_mop));
      chk("a.mulBusy", 32'(busy_a), 32'(e_busy));
      chk("a.stallCount", 32'(cnt_a), 32'(m_cnt16));
      chk("b.stall", 32'(stall_b), 32'(e_stall));
      chk("b.aluFire", 32'(alu_b), 32'(e_alu));
      chk("b.mulFire", 32'(mul_b), 32'(e_mul));
      chk("b.multOpcodeOut", 32'(mop_b), 32'(e_mop));
      chk("b.mulBusy", 32'(busy_b), 32'(e_busy));
      chk("b.stallCount", 32'(cnt_b), 32'(m_cnt4));

      @(posedge clk);
      rec.dst = v.dst;
      rec.issued = cyc;
      cyc++;
      if (v.rst) begin
         m_cnt16 = 0; m_cnt4 = 0;
         inflight.delete();
      end else begin
         if (e_stall) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (v.clr) inflight.delete();
         else if (e_mul) inflight.push_back(rec);
      end
      while (inflight.size() > 0 && cyc - inflight[0].issued > N) inflight.delete(0);
      #1;
   endtask

   initial begin
      in_t         v;
      logic [31:0] r, r2;

      drive(idle());
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      inflight.delete(); m_cnt16 = 0; m_cnt4 = 0;

      // Reset state, and an idle slot under robFull must not stall.
      tbl.push_back(row(idle(), 0, 0, 0, 0, 0));
      v = idle(); v.rob = 1'b1;
      tbl.push_back(row(v, 0, 0, 0, 0, 0));
      // RAW on MUL result: four stall cycles, then issue.
      tbl.push_back(row(mul_i(3), 0, 0, 1, 0, 0));
      tbl.push_back(row(alu_i(3, 1, 0, 0), 1, 0, 0, 1, 0));
      tbl.push_back(row(alu_i(3, 1, 0, 0), 1, 0, 0, 1, 1));
      tbl.push_back(row(alu_i(3, 1, 0, 0), 1, 0, 0, 1, 2));
      tbl.push_back(row(alu_i(3, 1, 0, 0), 1, 0, 0, 1, 3));
      tbl.push_back(row(alu_i(3, 1, 0, 0), 0, 1, 0, 0, 4));
      tbl.push_back(row(idle(), 0, 0, 0, 0, 4));
      // Writeback collision with an independent ALU op.
      tbl.push_back(row(mul_i(5), 0, 0, 1, 0, 4));
      tbl.push_back(row(idle(), 0, 0, 0, 1, 4));
      tbl.push_back(row(idle(), 0, 0, 0, 1, 4));
      tbl.push_back(row(alu_i(7, 1, 0, 0), 1, 0, 0, 1, 4));
      tbl.push_back(row(alu_i(7, 1, 0, 0), 0, 1, 0, 1, 5));
      tbl.push_back(row(idle(), 0, 0, 0, 0, 5));
      // Back-to-back MULs, busy drains four cycles after the last.
      for (int i = 1; i <= 4; i++) tbl.push_back(row(mul_i(i), 0, 0, 1, (i > 1), 5));
      for (int i = 4; i <= 7; i++) tbl.push_back(row(idle(), 0, 0, 0, 1, 5));
      tbl.push_back(row(idle(), 0, 0, 0, 0, 5));
      // Clear forgets the in-flight MUL and blocks issue in its own cycle.
      tbl.push_back(row(mul_i(3), 0, 0, 1, 0, 5));
      v = alu_i(9, 0, 9, 0); v.clr = 1'b1;
      tbl.push_back(row(v, 0, 0, 0, 1, 5));
      tbl.push_back(row(alu_i(0, 0, 3, 1), 0, 1, 0, 0, 5));

      foreach (tbl[i]) begin
         step(tbl[i].in);
         chk($sformatf("tbl%0d.stall", i), 32'(s_stall), 32'(tbl[i].stall));
         chk($sformatf("tbl%0d.aluFire", i), 32'(s_alu), 32'(tbl[i].alu));
         chk($sformatf("tbl%0d.mulFire", i), 32'(s_mul), 32'(tbl[i].mul));
         chk($sformatf("tbl%0d.multOpcodeOut", i), 32'(s_mop),
             tbl[i].mul ? 32'(OPCODE_MUL) : 32'(OPCODE_NOP));
         chk($sformatf("tbl%0d.mulBusy", i), 32'(s_busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d.stallCount", i), 32'(s_cnt16), tbl[i].cnt);
      end

      // ROB full for 20 cycles: the 4-bit counter pins at 15.
      for (int i = 0; i < 20; i++) begin
         v = alu_i(1, 1'b0, 2, 1'b0); v.rob = 1'b1;
         step(v);
      end
      step(idle());
      chk("sat cnt4", 32'(s_cnt4), 32'd15);
      chk("cnt16 after rob stalls", 32'(s_cnt16), 32'd25);

      // Reset mid-flight: MUL forgotten, counters zeroed, no fire in the reset cycle.
      step(mul_i(2));
      chk("mul before rst", 32'(s_mul), 32'd1);
      v = mul_i(6); v.rst = 1'b1;
      step(v);
      chk("no fire under rst", 32'(s_mul), 32'd0);
      chk("busy before rst edge", 32'(s_busy), 32'd1);
      step(alu_i(2, 1, 0, 0));
      chk("busy after rst", 32'(s_busy), 32'd0);
      chk("cnt16 after rst", 32'(s_cnt16), 32'd0);
      chk("cnt4 after rst", 32'(s_cnt4), 32'd0);
      chk("no raw after rst", 32'(s_stall), 32'd0);
      chk("alu fires after rst", 32'(s_alu), 32'd1);

      for (int i = 0; i < 400; i++) begin
         r  = $urandom;
         r2 = $urandom;
         v  = idle();
         v.valid = (r[2:0] != 3'd0);
         if (r[5:3] < 3'd3)       v.op = OPCODE_MUL;
         else if (r[5:3] == 3'd3) v.op = OPCODE_NOP;
         else                     v.op = r2[OPCODE_BITS-1:0];
         v.s1[2:0]  = r[8:6];
         v.s1u      = r[9];
         v.s2[2:0]  = r[12:10];
         v.s2u      = r[13];
         v.dst[2:0] = r[16:14];
         v.rob      = (r[19:17] == 3'd0);
         v.clr      = (r[24:20] == 5'd0);
         v.rst      = (r[30:25] == 6'd0);
         step(v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
